// File: rtl/i2s_sample_extract.sv
// i2s_sample_extract: pulls channel samples out of a 64-bit I2S frame, selects/averages, decimates, hands off over valid/ready.
// Optional DC-blocking stage after decimation when I2S_DC_BLOCK_EN is defined (adds one cycle of latency).
module i2s_sample_extract #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int DATA_OFFSET  = 1,
    parameter int DECIM_LOG2   = 0,
    parameter int DC_SHIFT     = 10
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           frame_valid_in,
    input  logic [63:0]                    frame_in,
    input  logic [1:0]                     channel_sel_in,
    output logic signed [SAMPLE_WIDTH-1:0] sample_out,
    output logic                           sample_valid_out,
    input  logic                           sample_ready_in,
    output logic                           overflow_out
);
    localparam int SW = SAMPLE_WIDTH;
    localparam int AW = SW + DECIM_LOG2;
    localparam logic [DECIM_LOG2:0] LAST = (DECIM_LOG2+1)'((1 << DECIM_LOG2) - 1);
    logic signed [SW-1:0] a, b, sel_val, s1_val, x, fin;
    logic signed [SW:0]   ab;
    logic signed [AW-1:0] acc, sum;
    logic [DECIM_LOG2:0]  cnt;
    logic                 s1_v, x_v, fin_v, unused_ok;
    // Channel words arrive MSB first, so bit order is reversed into the sample.
    always_comb begin
        a = '0;
        b = '0;
        for (int j = 0; j < SW; j++) begin
            a[SW-1-j] = frame_in[DATA_OFFSET+j];
            b[SW-1-j] = frame_in[32+DATA_OFFSET+j];
        end
        ab        = (SW+1)'(a) + (SW+1)'(b);
        sel_val   = channel_sel_in == 2'd1 ? b : channel_sel_in == 2'd2 ? SW'(ab >>> 1) : a;
        sum       = acc + AW'(s1_val);
        x         = SW'(sum >>> DECIM_LOG2);
        x_v       = s1_v && cnt == LAST;
        unused_ok = ^{frame_in, 32'(DC_SHIFT)};
    end
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_v   <= 1'b0;
            s1_val <= '0;
        end else begin
            s1_v <= frame_valid_in;
            if (frame_valid_in) s1_val <= sel_val;
        end
    end
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            acc <= '0;
            cnt <= '0;
        end else if (s1_v) begin
            acc <= cnt == LAST ? '0 : sum;
            cnt <= cnt == LAST ? '0 : cnt + 1'b1;
        end
    end
`ifdef I2S_DC_BLOCK_EN
    localparam int DW = SW + DC_SHIFT + 1;
    localparam logic signed [DW:0] SMAX = {{(DW-SW+2){1'b0}}, {(SW-1){1'b1}}};
    localparam logic signed [DW:0] SMIN = ~SMAX;
    logic signed [DW-1:0] d;
    logic signed [DW:0]   diff;
    always_comb diff = (DW+1)'(x) - (DW+1)'(d >>> DC_SHIFT);
    // The tracker integrates the unsaturated difference; only the output is clamped.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            d     <= '0;
            fin   <= '0;
            fin_v <= 1'b0;
        end else begin
            fin_v <= x_v;
            if (x_v) begin
                d   <= DW'((DW+1)'(d) + diff);
                fin <= diff > SMAX ? SW'(SMAX) : diff < SMIN ? SW'(SMIN) : SW'(diff);
            end
        end
    end
`else
    always_comb begin
        fin   = x;
        fin_v = x_v;
    end
`endif
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sample_out       <= '0;
            sample_valid_out <= 1'b0;
            overflow_out     <= 1'b0;
        end else begin
            if (sample_ready_in) sample_valid_out <= 1'b0;
            if (fin_v) begin
                if (!sample_valid_out || sample_ready_in) begin
                    sample_out       <= fin;
                    sample_valid_out <= 1'b1;
                end else begin
                    overflow_out <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_i2s_sample_extract.sv
// tb_i2s_sample_extract: scoreboard bench with a per-sample and a 4-sample decimating instance.
// Define I2S_DC_BLOCK_EN to exercise the DC-blocking build instead of the directed pipeline tests.
module tb_i2s_sample_extract;
    logic        clk = 1'b0;
    logic        rst, fv0, fv2, rdy0, rdy2, v0, v2, ov0, ov2;
    logic [63:0] frame;
    logic [1:0]  sel;
    logic [23:0] out0, out2, last0;
    logic [23:0] q0[$], q2[$];
    int          n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    i2s_sample_extract #(.DECIM_LOG2(0), .DC_SHIFT(4)) u0 (
        .clk_in(clk), .rst_in(rst), .frame_valid_in(fv0), .frame_in(frame), .channel_sel_in(sel),
        .sample_out(out0), .sample_valid_out(v0), .sample_ready_in(rdy0), .overflow_out(ov0));
    i2s_sample_extract #(.DECIM_LOG2(2), .DC_SHIFT(4)) u2 (
        .clk_in(clk), .rst_in(rst), .frame_valid_in(fv2), .frame_in(frame), .channel_sel_in(sel),
        .sample_out(out2), .sample_valid_out(v2), .sample_ready_in(rdy2), .overflow_out(ov2));

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && v0 && rdy0) begin
            last0 = out0;
            if (q0.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL u0 unexpected output: got %h expected none", out0);
            end else chk("u0 sample", out0, q0.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!rst && v2 && rdy2) begin
            if (q2.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL u2 unexpected output: got %h expected none", out2);
            end else chk("u2 sample", out2, q2.pop_front());
        end
    end

    // Bits outside the two channel fields are filled with noise.
    function automatic logic [63:0] mkframe(input logic [23:0] a, input logic [23:0] b);
        logic [63:0] f;
        f = {$urandom(), $urandom()};
        for (int j = 0; j < 24; j++) begin
            f[1+j]  = a[23-j];
            f[33+j] = b[23-j];
        end
        return f;
    endfunction

    task automatic send(input int inst, input logic [23:0] a, input logic [23:0] b, input logic [1:0] s);
        repeat (3) @(negedge clk);
        frame = mkframe(a, b);
        sel   = s;
        if (inst == 0) fv0 = 1'b1;
        else fv2 = 1'b1;
        @(negedge clk);
        fv0 = 1'b0;
        fv2 = 1'b0;
        sel = 2'($urandom());
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; fv0 = 1'b0; fv2 = 1'b0; rdy0 = 1'b1; rdy2 = 1'b1;
        frame = '0; sel = '0; last0 = '0;
        idle(3);
        chk("reset out0", out0, 24'd0);
        chk("reset valid0", 24'(v0), 24'd0);
        chk("reset ovf0", 24'(ov0), 24'd0);
        chk("reset out2", out2, 24'd0);
        chk("reset valid2", 24'(v2), 24'd0);
        chk("reset ovf2", 24'(ov2), 24'd0);
        rst = 1'b0;
`ifdef I2S_DC_BLOCK_EN
        begin
            longint d = 0, y;
            for (int i = 0; i < 200; i++) begin
                y = 1000 - (d >>> 4);
                d = d + y;
                q0.push_back(24'(y));
                send(0, 24'd1000, 24'd0, 2'd0);
            end
            idle(6);
            chk("dc decays below 10", 24'(last0 < 24'd10), 24'd1);
        end
`else
        q0.push_back(24'h123456);
        send(0, 24'h123456, 24'hABCDEF, 2'd0);
        chk("latency valid before", 24'(v0), 24'd0);
        idle(1);
        chk("latency valid at 2", 24'(v0), 24'd1);
        idle(1);
        chk("valid one cycle", 24'(v0), 24'd0);
        q0.push_back(24'hABCDEF); send(0, 24'h123456, 24'hABCDEF, 2'd1);
        q0.push_back(24'h000001); send(0, 24'h000003, 24'h000000, 2'd2);
        q0.push_back(24'hFFFFFE); send(0, 24'hFFFFFD, 24'h000000, 2'd2);
        q0.push_back(24'h7FFFFF); send(0, 24'h7FFFFF, 24'h7FFFFF, 2'd2);
        q0.push_back(24'h800000); send(0, 24'h800000, 24'h800000, 2'd2);
        q0.push_back(24'h000777); send(0, 24'h000777, 24'h000001, 2'd3);
        send(2, 24'd4, 24'd0, 2'd0);
        send(2, 24'd8, 24'd0, 2'd0);
        send(2, 24'hFFFFFC, 24'd0, 2'd0);
        idle(3);
        chk("no early decim output", 24'(v2), 24'd0);
        q2.push_back(24'd5); send(2, 24'd12, 24'd0, 2'd0);
        send(2, 24'hFFFFFF, 24'd0, 2'd0);
        send(2, 24'hFFFFFF, 24'd0, 2'd0);
        send(2, 24'hFFFFFF, 24'd0, 2'd0);
        q2.push_back(24'hFFFFFE); send(2, 24'hFFFFFE, 24'd0, 2'd0);
        idle(4);
        @(posedge clk); #1 rdy0 = 1'b0;
        q0.push_back(24'h000011); send(0, 24'h000011, 24'd0, 2'd0);
        send(0, 24'h000022, 24'd0, 2'd0);
        idle(3);
        chk("held sample", out0, 24'h000011);
        chk("held valid", 24'(v0), 24'd1);
        chk("overflow set", 24'(ov0), 24'd1);
        @(posedge clk); #1 rdy0 = 1'b1;
        idle(2);
        chk("valid drops after accept", 24'(v0), 24'd0);
        chk("overflow sticky", 24'(ov0), 24'd1);
        send(2, 24'd1000, 24'd0, 2'd0);
        send(2, 24'd1000, 24'd0, 2'd0);
        @(posedge clk); #1 rst = 1'b1;
        send(2, 24'd5000, 24'd0, 2'd0);
        @(posedge clk); #1 rst = 1'b0;
        q2.push_back(24'd100);
        repeat (4) send(2, 24'd100, 24'd0, 2'd0);
        idle(4);
        chk("ovf2 clear after reset", 24'(ov2), 24'd0);
        chk("ovf0 cleared by reset", 24'(ov0), 24'd0);
`endif
        for (int i = 0; i < 200 && (q0.size() != 0 || q2.size() != 0); i++) @(negedge clk);
        n_cmp++;
        if (q0.size() != 0 || q2.size() != 0) begin
            n_bad++;
            $display("FAIL drain: pending %0d/%0d expected 0/0", q0.size(), q2.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
